fifo_wr_packer: RTL and testbench

//  Write-side front end of the dual-clock flat FIFO, in the wclk domain.

---
 rtl/fifo_wr_packer.sv | 128 ++++++++++++
 tb/tb_fifo_wr_packer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_packer.sv
// fifo_wr_packer: packs RATIO narrow beats into one FIFO word, wclk domain.
// Define PACK_STATS_EN to add saturating stat_words/stat_stall counters.
module fifo_wr_packer #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_W-1:0]       s_data,
  input  logic                  s_last,
  input  logic                  flush,
  output logic [IN_W*RATIO-1:0] wdata,
  output logic                  winc,
  input  logic                  wfull
`ifdef PACK_STATS_EN
  ,
  output logic [15:0]           stat_words,
  output logic [15:0]           stat_stall
`endif
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int CW    = $clog2(RATIO);

  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] wdata_q, wdata_d;
  logic [OUT_W-1:0] lane;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_vld_q, out_vld_d;
  logic             fpend_q, fpend_d;
  logic             accept, flush_req;
  logic             cnt_nz, at_top, load;

  assign winc      = out_vld_q & ~wfull;
  assign s_ready   = ~out_vld_q | ~wfull;
  assign wdata     = wdata_q;
  assign accept    = s_valid & s_ready;
  assign flush_req = flush | fpend_q;
  assign cnt_nz    = cnt_q != '0;
  assign at_top    = cnt_q == CW'(RATIO - 1);

  // Incoming beat shifted into its lane; higher lanes of acc are already 0.
  always_comb begin
    lane = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (cnt_q == CW'(i)) begin
        lane[i*IN_W +: IN_W] = s_data;
      end
    end
  end

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    wdata_d   = wdata_q;
    out_vld_d = out_vld_q & ~winc;
    fpend_d   = 1'b0;
    load      = 1'b0;
    if (accept) begin
      if (at_top | s_last | flush_req) begin
        load = 1'b1;
      end else begin
        acc_d = acc_q | lane;
        cnt_d = cnt_q + 1'b1;
      end
    end else if (flush_req & cnt_nz) begin
      if (s_ready) begin
        load = 1'b1;
      end else begin
        fpend_d = 1'b1;
      end
    end
    if (load) begin
      wdata_d   = accept ? (acc_q | lane) : acc_q;
      out_vld_d = 1'b1;
      acc_d     = '0;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      wdata_q   <= '0;
      out_vld_q <= 1'b0;
      fpend_q   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      wdata_q   <= wdata_d;
      out_vld_q <= out_vld_d;
      fpend_q   <= fpend_d;
    end
  end

`ifdef PACK_STATS_EN
  logic [15:0] words_q, words_d;
  logic [15:0] stall_q, stall_d;

  always_comb begin
    words_d = words_q;
    stall_d = stall_q;
    if (winc && words_q != 16'hFFFF) begin
      words_d = words_q + 16'd1;
    end
    if (out_vld_q && wfull && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      words_q <= words_d;
      stall_q <= stall_d;
    end
  end

  assign stat_words = words_q;
  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_packer.sv
// tb_fifo_wr_packer: directed + random bench for fifo_wr_packer.
// A queue-based beat/word model checks every cycle; directed steps check constants.
module tb_fifo_wr_packer;

  localparam int IN_W  = 8;
  localparam int RATIO = 4;
  localparam int OUT_W = IN_W * RATIO;

  logic             wclk    = 1'b0;
  logic             wrst_n  = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_last  = 1'b0;
  logic             flush   = 1'b0;
  logic             wfull   = 1'b0;
  logic [IN_W-1:0]  s_data  = '0;
  logic             s_ready;
  logic             winc;
  logic [OUT_W-1:0] wdata;
`ifdef PACK_STATS_EN
  logic [15:0]      stat_words;
  logic [15:0]      stat_stall;
`endif

  int n_run  = 0;
  int n_fail = 0;

  always #5 wclk = ~wclk;

  fifo_wr_packer #(.IN_W(IN_W), .RATIO(RATIO)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .flush     (flush),
    .wdata     (wdata),
    .winc      (winc),
    .wfull     (wfull)
`ifdef PACK_STATS_EN
    ,
    .stat_words(stat_words),
    .stat_stall(stat_stall)
`endif
  );

  task automatic chk(input string tag,
                     input logic [OUT_W-1:0] obs,
                     input logic [OUT_W-1:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: list of pending beats, one held output word.
  logic [IN_W-1:0]  beats[$];
  logic [OUT_W-1:0] got[$];
  logic [OUT_W-1:0] held = '0;
  bit               hold = 0;
  bit               pend = 0;
  int               m_words = 0;
  int               m_stall = 0;

  function automatic logic [OUT_W-1:0] pack_beats();
    logic [OUT_W-1:0] w;
    w = '0;
    foreach (beats[i]) w[i*IN_W +: IN_W] = beats[i];
    return w;
  endfunction

  always @(negedge wclk) begin
    bit er;
    if (!wrst_n) begin
      chk("winc_in_reset", OUT_W'(winc), '0);
      beats.delete();
      hold    = 0;
      pend    = 0;
      m_words = 0;
      m_stall = 0;
    end else begin
`ifdef PACK_STATS_EN
      chk("stat_words", OUT_W'(stat_words), OUT_W'(m_words));
      chk("stat_stall", OUT_W'(stat_stall), OUT_W'(m_stall));
`endif
      er = !(hold && wfull);
      chk("s_ready", OUT_W'(s_ready), OUT_W'(er));
      chk("winc", OUT_W'(winc), OUT_W'(hold && !wfull));
      if (hold && wfull && m_stall < 65535) m_stall++;
      if (hold && !wfull) begin
        chk("wdata", wdata, held);
        got.push_back(wdata);
        hold = 0;
        if (m_words < 65535) m_words++;
      end
      if (s_valid && er) begin
        beats.push_back(s_data);
        if (beats.size() == RATIO || s_last || flush || pend) begin
          held = pack_beats();
          hold = 1;
          pend = 0;
          beats.delete();
        end
      end else if (flush || pend) begin
        if (beats.size() != 0) begin
          if (er) begin
            held = pack_beats();
            hold = 1;
            pend = 0;
            beats.delete();
          end else begin
            pend = 1;
          end
        end else begin
          pend = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic beat(input logic [IN_W-1:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    flush   = 1'b0;
    tick();
  endtask

  task automatic idle(input logic fl);
    s_valid = 1'b0;
    s_last  = 1'b0;
    flush   = fl;
    tick();
    flush   = 1'b0;
  endtask

  logic [IN_W-1:0]  b8[8];
  logic [OUT_W-1:0] w0, w1;
  int               acc_n;
  bit               took;

  initial begin
    wrst_n = 1'b0;
    tick();
    tick();
    wrst_n = 1'b1;
    #1;
    chk("ready_after_rst", OUT_W'(s_ready), 1);
    chk("winc_after_rst", OUT_W'(winc), 0);
    tick();

    // 1: full word, latency one cycle
    got.delete();
    beat(8'h11, 0);
    beat(8'h22, 0);
    beat(8'h33, 0);
    beat(8'h44, 0);
    s_valid = 1'b0;
    chk("t1_latency_winc", OUT_W'(winc), 1);
    chk("t1_latency_wdata", wdata, 32'h44332211);
    idle(0);
    idle(0);
    chk("t1_count", OUT_W'(got.size()), 1);
    if (got.size() > 0) chk("t1_word", got[0], 32'h44332211);

    // 2: s_last partial word, then lane 0 restarts
    got.delete();
    beat(8'hAA, 0);
    beat(8'hBB, 1);
    beat(8'hCC, 1);
    idle(0);
    idle(0);
    chk("t2_count", OUT_W'(got.size()), 2);
    if (got.size() > 1) begin
      chk("t2_word0", got[0], 32'h0000BBAA);
      chk("t2_word1", got[1], 32'h000000CC);
    end

    // 3: backpressure with 8 beats
    got.delete();
    foreach (b8[i]) b8[i] = IN_W'($urandom);
    for (int i = 0; i < 4; i++) begin
      w0[i*IN_W +: IN_W] = b8[i];
      w1[i*IN_W +: IN_W] = b8[i+4];
    end
    wfull = 1'b1;
    acc_n = 0;
    for (int c = 0; c < 8; c++) begin
      s_valid = 1'b1;
      s_last  = 1'b0;
      s_data  = b8[acc_n];
      #1;
      took = s_ready;
      tick();
      if (took) acc_n++;
    end
    chk("t3_accepted_while_full", OUT_W'(acc_n), 4);
    chk("t3_ready_low", OUT_W'(s_ready), 0);
    chk("t3_no_write", OUT_W'(got.size()), 0);
    wfull = 1'b0;
    for (int c = 0; c < 20 && acc_n < 8; c++) begin
      s_valid = 1'b1;
      s_data  = b8[acc_n];
      #1;
      took = s_ready;
      tick();
      if (took) acc_n++;
    end
    chk("t3_all_accepted", OUT_W'(acc_n), 8);
    idle(0);
    idle(0);
    chk("t3_count", OUT_W'(got.size()), 2);
    if (got.size() > 1) begin
      chk("t3_word0", got[0], w0);
      chk("t3_word1", got[1], w1);
    end

    // 4: flush partial, then empty flush
    got.delete();
    beat(8'h5A, 0);
    idle(1);
    idle(0);
    idle(0);
    idle(1);
    idle(0);
    idle(0);
    chk("t4_count", OUT_W'(got.size()), 1);
    if (got.size() > 0) chk("t4_word", got[0], 32'h0000005A);

    // 5: reset mid-word
    got.delete();
    beat(8'h01, 0);
    beat(8'h02, 0);
    s_valid = 1'b0;
    wrst_n  = 1'b0;
    tick();
    tick();
    wrst_n = 1'b1;
    beat(8'hD1, 0);
    beat(8'hD2, 0);
    beat(8'hD3, 0);
    beat(8'hD4, 0);
    idle(0);
    idle(0);
    chk("t5_count", OUT_W'(got.size()), 1);
    if (got.size() > 0) chk("t5_word", got[0], 32'hD4D3D2D1);

    // 6: three words, five stall cycles
    wrst_n = 1'b0;
    tick();
    wrst_n = 1'b1;
    tick();
    got.delete();
    for (int i = 0; i < 4; i++) beat(IN_W'(i + 1), 0);
    s_valid = 1'b0;
    wfull   = 1'b1;
    for (int c = 0; c < 5; c++) idle(0);
    wfull = 1'b0;
    idle(0);
    for (int i = 0; i < 8; i++) beat(IN_W'($urandom), 0);
    idle(0);
    idle(0);
    chk("t6_words", OUT_W'(got.size()), 3);
`ifdef PACK_STATS_EN
    chk("t6_stat_words", OUT_W'(stat_words), 3);
    chk("t6_stat_stall", OUT_W'(stat_stall), 5);
`endif

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = IN_W'($urandom);
      s_last  = ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 7) == 0);
      wfull   = ($urandom_range(0, 2) == 0);
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    wfull   = 1'b0;
    idle(1);
    idle(0);
    idle(0);
    chk("drain_ready", OUT_W'(s_ready), 1);
    chk("drain_winc", OUT_W'(winc), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
